// File: rtl/red_reduce_seq_pkg.sv
// Shared types and widths for the RED byte-reduction unit.
package red_pkg;

  localparam int BYTE_W = 8;
  localparam int SUM_W  = 9;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    LO   = 3'd1,
    HI   = 3'd2,
    FIN  = 3'd3,
    DONE = 3'd4
  } state_t;

endpackage

// File: rtl/red_reduce_seq_if.sv
// Operand/result handshake bundle between ID-EX and the EX result mux.
interface red_reduce_seq_if #(
  parameter int DW = 16
);

  logic          in_valid;
  logic          in_ready;
  logic [DW-1:0] rs;
  logic [DW-1:0] rt;
  logic          out_valid;
  logic          out_ready;
  logic [DW-1:0] result;

  modport master (
    output in_valid, rs, rt, out_ready,
    input  in_ready, out_valid, result
  );

  modport slave (
    input  in_valid, rs, rt, out_ready,
    output in_ready, out_valid, result
  );

endinterface

// File: rtl/red_reduce_seq_cla.sv
// 9-bit carry-lookahead adder, every carry expanded flat from g/p and cin.
// Latency: combinational.
// Backpressure: none.
module red_cla9
  import red_pkg::*;
(
  input  logic [SUM_W-1:0] a,
  input  logic [SUM_W-1:0] b,
  input  logic             cin,
  output logic [SUM_W-1:0] sum,
  output logic             cout
);

  logic [SUM_W-1:0] g;
  logic [SUM_W-1:0] p;
  logic [SUM_W:0]   c;
  logic             prod;
  logic             term;

  always_comb begin
    g    = a & b;
    p    = a ^ b;
    c    = '0;
    prod = 1'b0;
    term = 1'b0;
    c[0] = cin;
    // c[i] = OR over k of g[k] & p[k+1..i-1], plus cin & p[0..i-1]
    for (int i = 1; i <= SUM_W; i++) begin
      term = 1'b0;
      for (int k = 0; k < i; k++) begin
        prod = g[k];
        for (int m = k + 1; m < i; m++) begin
          prod = prod & p[m];
        end
        term = term | prod;
      end
      prod = cin;
      for (int m = 0; m < i; m++) begin
        prod = prod & p[m];
      end
      c[i] = term | prod;
    end
    sum  = p ^ c[SUM_W-1:0];
    cout = c[SUM_W];
  end

endmodule

// File: rtl/red_reduce_seq.sv
// Sums the four bytes of rs and rt using one shared 9-bit adder over three passes.
// Latency: result valid on the 4th edge counting the accept edge; one result per 4 cycles.
// Backpressure: result held in DONE until out_ready; a new accept may coincide with the take.
module red_reduce_seq
  import red_pkg::*;
#(
  parameter int DW   = 16,
  parameter bit SEXT = 1'b0
)(
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  red_reduce_seq_if.slave  bus,
  output logic             busy
);

  localparam int EXT_W = DW - SUM_W - 1;

  state_t           state_q;
  state_t           state_d;
  logic [DW-1:0]    rs_q;
  logic [DW-1:0]    rt_q;
  logic [SUM_W-1:0] sum_lo_q;
  logic [SUM_W-1:0] sum_hi_q;
  logic [DW-1:0]    result_q;
  logic             out_valid_q;

  logic             accept;
  logic [SUM_W-1:0] add_a;
  logic [SUM_W-1:0] add_b;
  logic [SUM_W-1:0] add_s;
  logic             add_co;
  logic [SUM_W:0]   red_sum;
  logic [DW-1:0]    red_ext;

  assign bus.in_ready  = (state_q == IDLE) || ((state_q == DONE) && bus.out_ready);
  assign accept        = bus.in_valid && bus.in_ready && !flush;
  assign bus.out_valid = out_valid_q;
  assign bus.result    = result_q;
  assign busy          = (state_q != IDLE);

  always_comb begin
    state_d = state_q;
    add_a   = '0;
    add_b   = '0;
    unique case (state_q)
      IDLE: begin
        if (accept) state_d = LO;
      end
      LO: begin
        add_a   = {1'b0, rs_q[BYTE_W-1:0]};
        add_b   = {1'b0, rt_q[BYTE_W-1:0]};
        state_d = flush ? IDLE : HI;
      end
      HI: begin
        add_a   = {1'b0, rs_q[DW-1:BYTE_W]};
        add_b   = {1'b0, rt_q[DW-1:BYTE_W]};
        state_d = flush ? IDLE : FIN;
      end
      FIN: begin
        add_a   = sum_lo_q;
        add_b   = sum_hi_q;
        state_d = flush ? IDLE : DONE;
      end
      DONE: begin
        if (flush)              state_d = IDLE;
        else if (bus.out_ready) state_d = accept ? LO : IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  red_cla9 u_add (
    .a    (add_a),
    .b    (add_b),
    .cin  (1'b0),
    .sum  (add_s),
    .cout (add_co)
  );

  // The combine pass needs the adder carry as bit 9 of the reduction.
  assign red_sum = {add_co, add_s};
  assign red_ext = SEXT ? {{EXT_W{red_sum[SUM_W]}}, red_sum}
                        : {{EXT_W{1'b0}}, red_sum};

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      rs_q        <= '0;
      rt_q        <= '0;
      sum_lo_q    <= '0;
      sum_hi_q    <= '0;
      result_q    <= '0;
      out_valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        rs_q <= bus.rs;
        rt_q <= bus.rt;
      end
      if (flush) begin
        out_valid_q <= 1'b0;
      end else begin
        unique case (state_q)
          LO:   sum_lo_q <= add_s;
          HI:   sum_hi_q <= add_s;
          FIN: begin
            result_q    <= red_ext;
            out_valid_q <= 1'b1;
          end
          DONE: begin
            if (bus.out_ready) out_valid_q <= 1'b0;
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_red_reduce_seq.sv
// Scoreboard bench: two instances (zero- and sign-extending) share one stimulus stream.
module tb_red_reduce_seq;

  logic        clk = 1'b0;
  logic        rst;
  logic        flush;
  logic        in_valid;
  logic [15:0] rs;
  logic [15:0] rt;
  logic        dir_ready;
  logic        rnd_ready;
  logic        rand_mode;
  logic        busy0;
  logic        busy1;

  int checks   = 0;
  int errors   = 0;
  int issued   = 0;
  int received = 0;
  int exp_q[$];

  always #5 clk = ~clk;

  red_reduce_seq_if #(.DW(16)) bus0 ();
  red_reduce_seq_if #(.DW(16)) bus1 ();

  assign bus0.in_valid  = in_valid;
  assign bus0.rs        = rs;
  assign bus0.rt        = rt;
  assign bus0.out_ready = rand_mode ? rnd_ready : dir_ready;
  assign bus1.in_valid  = in_valid;
  assign bus1.rs        = rs;
  assign bus1.rt        = rt;
  assign bus1.out_ready = rand_mode ? rnd_ready : dir_ready;

  red_reduce_seq #(.DW(16), .SEXT(1'b0)) dut0 (
    .clk   (clk),
    .rst   (rst),
    .flush (flush),
    .bus   (bus0),
    .busy  (busy0)
  );

  red_reduce_seq #(.DW(16), .SEXT(1'b1)) dut1 (
    .clk   (clk),
    .rst   (rst),
    .flush (flush),
    .bus   (bus1),
    .busy  (busy1)
  );

  function automatic int model(input logic [15:0] a, input logic [15:0] b);
    return int'(a[15:8]) + int'(a[7:0]) + int'(b[15:8]) + int'(b[7:0]);
  endfunction

  function automatic int sext(input int s);
    return (s >= 512) ? (s | 32'h0000_FC00) : s;
  endfunction

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  always @(posedge clk) begin
    #1;
    rnd_ready = ($urandom_range(0, 3) != 0);
  end

  // Output monitor: every consumed result must be the oldest outstanding expectation.
  always @(negedge clk) begin
    if (!rst && bus0.out_valid && bus0.out_ready) begin
      int e;
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL sb_unexpected: got %0h expected no result", bus0.result);
      end else begin
        e = exp_q.pop_front();
        received++;
        check("sb_zext", int'(bus0.result), e);
        check("sb_sext", int'(bus1.result), sext(e));
        check("sb_valid_pair", int'(bus1.out_valid), 1);
      end
    end
  end

  // Called just after a rising edge; returns just after the accepting edge.
  task automatic issue(input logic [15:0] a, input logic [15:0] b, output int waits);
    waits    = 0;
    in_valid = 1'b1;
    rs       = a;
    rt       = b;
    while (1) begin
      @(negedge clk);
      if (bus0.in_ready && !flush) begin
        exp_q.push_back(model(a, b));
        issued++;
        break;
      end
      waits++;
      if (waits > 100) begin
        checks++;
        errors++;
        $display("FAIL accept_timeout: got no accept expected accept within 100 cycles");
        break;
      end
      @(posedge clk);
      #1;
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  // Ends on a falling edge with out_valid high, or reports a timeout.
  task automatic wait_valid(input string name);
    int n;
    n = 0;
    @(negedge clk);
    while (!bus0.out_valid && n < 30) begin
      @(negedge clk);
      n++;
    end
    if (!bus0.out_valid) begin
      checks++;
      errors++;
      $display("FAIL %s: got out_valid=0 expected out_valid=1 within 30 cycles", name);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got no finish expected finish before time limit");
    $fatal(1);
  end

  initial begin
    int w;
    int n;
    logic [15:0] ra;
    logic [15:0] rb;

    rst       = 1'b1;
    flush     = 1'b0;
    in_valid  = 1'b0;
    rs        = '0;
    rt        = '0;
    dir_ready = 1'b1;
    rand_mode = 1'b0;

    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_out_valid", int'(bus0.out_valid), 0);
    check("rst_result", int'(bus0.result), 0);
    check("rst_busy", int'(busy0), 0);
    check("rst_in_ready", int'(bus0.in_ready), 1);
    check("rst_busy_sext", int'(busy1), 0);
    check("rst_in_ready_sext", int'(bus1.in_ready), 1);
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(posedge clk);
    #1;

    // Latency: out_valid appears only after the 4th edge from accept.
    issue(16'h0102, 16'h0304, w);
    for (int i = 1; i <= 4; i++) begin
      @(negedge clk);
      check("lat_out_valid", int'(bus0.out_valid), int'(i == 4));
      if (i < 4) begin
        check("lat_busy", int'(busy0), 1);
        @(posedge clk);
      end
    end
    check("basic_result", int'(bus0.result), 16'h000A);
    check("basic_result_sext", int'(bus1.result), 16'h000A);
    @(posedge clk);
    @(negedge clk);
    check("basic_idle_valid", int'(bus0.out_valid), 0);
    check("basic_idle_busy", int'(busy0), 0);
    check("basic_result_hold", int'(bus0.result), 16'h000A);
    @(posedge clk);
    #1;

    issue(16'hFFFF, 16'hFFFF, w);
    wait_valid("max_timeout");
    check("max_result", int'(bus0.result), 16'h03FC);
    check("max_result_sext", int'(bus1.result), 16'hFFFC);
    @(posedge clk);
    #1;

    // Backpressure stall, then a take with a same-cycle accept.
    dir_ready = 1'b0;
    issue(16'h0001, 16'h0002, w);
    wait_valid("stall_timeout");
    @(posedge clk);
    #1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("stall_valid", int'(bus0.out_valid), 1);
      check("stall_result", int'(bus0.result), 16'h0003);
      check("stall_in_ready", int'(bus0.in_ready), 0);
      @(posedge clk);
      #1;
    end
    dir_ready = 1'b1;
    issue(16'h0010, 16'h0020, w);
    check("b2b_same_cycle", w, 0);
    @(negedge clk);
    check("b2b_valid_drop", int'(bus0.out_valid), 0);
    check("b2b_busy", int'(busy0), 1);
    wait_valid("b2b_timeout");
    check("b2b_result", int'(bus0.result), 16'h0030);
    @(posedge clk);
    #1;

    // Flush while in HI: operation dropped, previous result retained.
    issue(16'h0005, 16'h0006, w);
    @(posedge clk);
    #1;
    flush = 1'b1;
    @(negedge clk);
    check("flush_busy_before", int'(busy0), 1);
    @(posedge clk);
    #1;
    flush = 1'b0;
    void'(exp_q.pop_back());
    issued--;
    @(negedge clk);
    check("flush_busy", int'(busy0), 0);
    check("flush_valid", int'(bus0.out_valid), 0);
    check("flush_result_hold", int'(bus0.result), 16'h0030);
    repeat (6) begin
      @(negedge clk);
      check("flush_no_valid", int'(bus0.out_valid), 0);
    end
    @(posedge clk);
    #1;
    flush    = 1'b1;
    in_valid = 1'b1;
    rs       = 16'h0040;
    rt       = 16'h0001;
    @(posedge clk);
    #1;
    flush    = 1'b0;
    in_valid = 1'b0;
    @(negedge clk);
    check("flush_beats_accept", int'(busy0), 0);
    check("flush_idle_result", int'(bus0.result), 16'h0030);
    @(posedge clk);
    #1;

    // Reset while in FIN.
    issue(16'h0007, 16'h0008, w);
    @(posedge clk);
    @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    void'(exp_q.pop_back());
    issued--;
    @(negedge clk);
    check("midrst_valid", int'(bus0.out_valid), 0);
    check("midrst_result", int'(bus0.result), 0);
    check("midrst_result_sext", int'(bus1.result), 0);
    check("midrst_busy", int'(busy0), 0);
    @(posedge clk);
    #1;
    issue(16'h8080, 16'h8080, w);
    wait_valid("midrst_next_timeout");
    check("midrst_next_result", int'(bus0.result), 16'h0200);
    check("midrst_next_sext", int'(bus1.result), 16'hFE00);
    @(posedge clk);
    #1;

    // Random regression with random consumer readiness.
    rand_mode = 1'b1;
    for (int i = 0; i < 1000; i++) begin
      ra = 16'($urandom);
      rb = 16'($urandom);
      issue(ra, rb, w);
      if ($urandom_range(0, 3) == 0) begin
        repeat ($urandom_range(1, 3)) @(posedge clk);
        #1;
      end
    end
    rand_mode = 1'b0;
    dir_ready = 1'b1;
    n = 0;
    while (exp_q.size() > 0 && n < 200) begin
      @(posedge clk);
      n++;
    end
    @(negedge clk);
    check("drain_empty", exp_q.size(), 0);
    check("result_count", received, issued);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/red_reduce_seq.md
Name: red_reduce_seq

Overview:
- Multi-cycle byte-reduction unit for the RED datapath.
- Accepts two 16-bit operands and produces the 16-bit sum of their four bytes.
- Time-multiplexes one 9-bit carry-lookahead adder over three passes: low bytes, high bytes, combine.
- Sits between the register-read/ID-EX stage and the EX result mux, with a valid/ready handshake on both sides.

Parameters:
- DW, 16, operand and result width (only 16 is supported).
- SEXT, 0, 0 = zero-extend the 10-bit reduction to DW; 1 = sign-extend from bit 9.

Ports:
- clk  input  1  system clock; all state changes on the rising edge.
- rst  input  1  synchronous, active-high reset.
- flush  input  1  synchronous abort of any in-flight or held operation.
- in_valid  input  1  operands present.
- in_ready  output  1  unit can accept operands this cycle.
- rs  input  16  operand A.
- rt  input  16  operand B.
- out_valid  output  1  result valid.
- out_ready  input  1  consumer takes the result this cycle.
- result  output  16  reduction result.
- busy  output  1  high in any state other than IDLE.

Behaviour:
- Reset (rst=1 at an edge): state=IDLE, out_valid=0, result=0, busy=0, and all internal registers cleared. Reset wins over every other input.
- Flush: next state=IDLE, out_valid=0, in-flight data dropped, result not updated. Flush beats an in_valid in the same cycle: nothing is accepted. Flush has no effect when already IDLE.
- Accept: occurs on an edge where in_valid && in_ready && !flush. rs and rt are latched at that edge.
- in_ready = (state==IDLE) || (state==DONE && out_ready).
- FSM: IDLE -> LO -> HI -> FIN -> DONE.
  - IDLE: wait for an accept.
  - LO: adder computes {1'b0,rs[7:0]} + {1'b0,rt[7:0]}, cin=0. The 9-bit value sum_lo is registered.
  - HI: adder computes rs[15:8] + rt[15:8]. The 9-bit value sum_hi is registered.
  - FIN: adder computes sum_lo + sum_hi. The 10-bit value {cout,sum} is extended per SEXT and registered into result; out_valid is set.
  - DONE: hold result and out_valid until out_ready=1.
    - On out_ready without a new accept: go to IDLE and clear out_valid.
    - On out_ready with a same-cycle accept: go to LO (back-to-back operation).
- Latency: out_valid rises at the 4th rising edge counting the accepting edge as the 1st. With back-to-back operations, throughput is one result per 4 cycles.
- Stall: while DONE and out_ready=0, result is stable and no input is accepted.
- Width rules:
  - Byte sums are unsigned and at most 510 (fits 9 bits).
  - The combined sum is at most 1020 (fits 10 bits).
  - No overflow is possible, and the arithmetic has no saturation.
- Adder operand selection is a 3-way mux keyed on state. The adder inputs are don't-care in IDLE and DONE.
- result holds its last value after the handshake completes, until the next FIN or a reset.

Decomposition:
- Package red_pkg holds:
  - the state enum (IDLE, LO, HI, FIN, DONE), 3-bit encoded;
  - localparams BYTE_W=8 and SUM_W=9.
- The FSM, operand latches, sum_lo/sum_hi/result registers and extension logic form this module's own body.
- One sub-module instance: the team's existing 9-bit carry-lookahead adder, instantiated once as u_add and driven by the state mux.

Test Plan:
- Basic, SEXT=0: after reset, rs=16'h0102, rt=16'h0304 -> out_valid at the 4th edge from accept, result=16'h000A.
- Maximum values: rs=16'hFFFF, rt=16'hFFFF -> result=16'h03FC (1020). With SEXT=1 the same inputs give result=16'hFFFC.
- Backpressure: hold out_ready=0 for 5 cycles after out_valid -> result and out_valid stable, in_ready=0. Then pulse out_ready with in_valid high (rs=16'h0010, rt=16'h0020) -> the new operation is accepted the same cycle, and the next result is 16'h0030.
- Flush mid-operation: flush in state HI -> IDLE next cycle, out_valid never asserts, and the previous result value is retained. A flush coinciding with in_valid in IDLE -> no accept occurs.
- Reset mid-operation: rst in FIN -> out_valid=0, result=0, state IDLE. The next operation, rs=16'h8080, rt=16'h8080 -> result=16'h0200.
- Random regression: 1000 random rs/rt pairs with random out_ready -> every result equals the sum of the four bytes, and no result is lost or duplicated.
